// File: rtl/divider_seq_param.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq_param
// Description : Sequential restoring divider. Divides a 2N-bit dividend by an
//               N-bit divisor, one quotient bit per clock. Supports unsigned
//               and two's-complement (truncating) modes. Reports overflow and
//               divide-by-zero. Start is rising-edge qualified.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_seq_param #(
    parameter int N = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [2*N-1:0]   DIVIDEND,
    input  logic [N-1:0]     DIVISOR,
    input  logic             SIGNED,
    input  logic             Start,
    output logic [N-1:0]     Quo,
    output logic [N-1:0]     Rem,
    output logic             Finish,
    output logic             Busy,
    output logic             OV,
    output logic             DIVBYZERO
);

    localparam int c_CNT_W = $clog2(N) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Registered state
    state_t               r_state;
    logic                 r_start_d;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [N-1:0]         r_prem;     // partial remainder magnitude
    logic [N-1:0]         r_qwork;    // low dividend bits shifting into quotient
    logic [N-1:0]         r_bmag;     // divisor magnitude
    logic                 r_signed;
    logic                 r_qneg;
    logic                 r_rneg;

    // Next-state values
    state_t               w_state;
    logic [c_CNT_W-1:0]   w_cnt;
    logic [N-1:0]         w_prem;
    logic [N-1:0]         w_qwork;
    logic [N-1:0]         w_bmag;
    logic                 w_signed;
    logic                 w_qneg;
    logic                 w_rneg;
    logic [N-1:0]         w_quo;
    logic [N-1:0]         w_rem;
    logic                 w_finish;
    logic                 w_busy;
    logic                 w_ov;
    logic                 w_dbz;

    // Operand conditioning, evaluated on the acceptance edge only
    logic                 w_accept;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [2*N-1:0]       w_a_mag;
    logic [N-1:0]         w_b_mag;

    // One restoring step: the shifted remainder is below 2*|B|, so one extra
    // bit beyond N+1 is enough to expose the borrow as a sign bit.
    logic [N:0]           w_shift;
    logic [N+1:0]         w_trial;

    // Signed range check of the quotient magnitude
    logic                 w_range_ov;

    assign w_accept = Start & ~r_start_d & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_a_neg  = SIGNED & DIVIDEND[2*N-1];
    assign w_b_neg  = SIGNED & DIVISOR[N-1];
    assign w_a_mag  = w_a_neg ? (~DIVIDEND + (2*N)'(1)) : DIVIDEND;
    assign w_b_mag  = w_b_neg ? (~DIVISOR + N'(1)) : DIVISOR;

    assign w_shift  = {r_prem, r_qwork[N-1]};
    assign w_trial  = {1'b0, w_shift} - {2'b00, r_bmag};

    // Negative results may reach 2^(N-1); positive ones must stay below it.
    assign w_range_ov = r_signed & (r_qneg ? (r_qwork[N-1] & (|r_qwork[N-2:0]))
                                           : r_qwork[N-1]);

    // Next-state and datapath update logic
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_prem   = r_prem;
        w_qwork  = r_qwork;
        w_bmag   = r_bmag;
        w_signed = r_signed;
        w_qneg   = r_qneg;
        w_rneg   = r_rneg;
        w_quo    = Quo;
        w_rem    = Rem;
        w_finish = Finish;
        w_busy   = Busy;
        w_ov     = OV;
        w_dbz    = DIVBYZERO;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (DIVISOR == '0) begin
                        w_state  = S_DONE;
                        w_finish = 1'b1;
                        w_busy   = 1'b0;
                        w_dbz    = 1'b1;
                        w_ov     = 1'b0;
                        w_quo    = '0;
                        w_rem    = '0;
                    end else if (w_a_mag[2*N-1:N] >= w_b_mag) begin
                        w_state  = S_DONE;
                        w_finish = 1'b1;
                        w_busy   = 1'b0;
                        w_dbz    = 1'b0;
                        w_ov     = 1'b1;
                        w_quo    = '0;
                        w_rem    = '0;
                    end else begin
                        w_state  = S_CALC;
                        w_prem   = w_a_mag[2*N-1:N];
                        w_qwork  = w_a_mag[N-1:0];
                        w_bmag   = w_b_mag;
                        w_signed = SIGNED;
                        w_qneg   = w_a_neg ^ w_b_neg;
                        w_rneg   = w_a_neg;
                        w_cnt    = '0;
                        w_busy   = 1'b1;
                        w_finish = 1'b0;
                        w_ov     = 1'b0;
                        w_dbz    = 1'b0;
                    end
                end
            end
            S_CALC: begin
                if (!w_trial[N+1]) begin
                    w_prem  = w_trial[N-1:0];
                    w_qwork = {r_qwork[N-2:0], 1'b1};
                end else begin
                    w_prem  = w_shift[N-1:0];
                    w_qwork = {r_qwork[N-2:0], 1'b0};
                end
                w_cnt = r_cnt + c_CNT_W'(1);
                if (r_cnt == c_LAST_ITER) begin
                    w_state = S_FIX;
                end
            end
            S_FIX: begin
                if (w_range_ov) begin
                    w_ov  = 1'b1;
                    w_quo = '0;
                    w_rem = '0;
                end else begin
                    w_quo = r_qneg ? (~r_qwork + N'(1)) : r_qwork;
                    w_rem = r_rneg ? (~r_prem + N'(1)) : r_prem;
                end
                w_busy   = 1'b0;
                w_finish = 1'b1;
                w_state  = S_DONE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_cnt     <= '0;
            r_prem    <= '0;
            r_qwork   <= '0;
            r_bmag    <= '0;
            r_signed  <= 1'b0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            Quo       <= '0;
            Rem       <= '0;
            Finish    <= 1'b0;
            Busy      <= 1'b0;
            OV        <= 1'b0;
            DIVBYZERO <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_start_d <= Start;
            r_cnt     <= w_cnt;
            r_prem    <= w_prem;
            r_qwork   <= w_qwork;
            r_bmag    <= w_bmag;
            r_signed  <= w_signed;
            r_qneg    <= w_qneg;
            r_rneg    <= w_rneg;
            Quo       <= w_quo;
            Rem       <= w_rem;
            Finish    <= w_finish;
            Busy      <= w_busy;
            OV        <= w_ov;
            DIVBYZERO <= w_dbz;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider_seq_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_seq_param
// Description : Directed self-checking bench for divider_seq_param (N=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_seq_param;

    localparam int N = 5;

    logic             CLK;
    logic             RST;
    logic [2*N-1:0]   DIVIDEND;
    logic [N-1:0]     DIVISOR;
    logic             SIGNED;
    logic             Start;
    logic [N-1:0]     Quo;
    logic [N-1:0]     Rem;
    logic             Finish;
    logic             Busy;
    logic             OV;
    logic             DIVBYZERO;

    int n_checks = 0;
    int n_fail   = 0;

    divider_seq_param #(.N(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DIVIDEND  (DIVIDEND),
        .DIVISOR   (DIVISOR),
        .SIGNED    (SIGNED),
        .Start     (Start),
        .Quo       (Quo),
        .Rem       (Rem),
        .Finish    (Finish),
        .Busy      (Busy),
        .OV        (OV),
        .DIVBYZERO (DIVBYZERO)
    );

    // Free-running clock, period 10
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch one operation and check latency and result. Start is held for
    // edges 0 and 1. If repulse is nonzero, Start is pulsed again mid-CALC.
    task automatic do_op(input string tag, input logic [2*N-1:0] a, input logic [N-1:0] b,
                         input logic s, input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic eov, input logic edbz, input int lat, input bit repulse);
        int n;
        DIVIDEND = a;
        DIVISOR  = b;
        SIGNED   = s;
        Start    = 1'b1;
        step();                         // edge 0: acceptance
        // Scramble operands: result must not depend on them after acceptance
        DIVIDEND = ~a;
        DIVISOR  = b + 5'd3;
        SIGNED   = ~s;
        n = 0;
        while (Finish !== 1'b1 && n < 20) begin
            chk({tag, "_busy"}, Busy, 1);
            step();
            n++;
            if (n == 1) Start = 1'b0;
            if (repulse && n == 2) Start = 1'b1;
            if (repulse && n == 3) Start = 1'b0;
        end
        Start = 1'b0;
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_busy_done"}, Busy, 0);
        chk({tag, "_quo"}, Quo, eq);
        chk({tag, "_rem"}, Rem, er);
        chk({tag, "_ov"}, OV, eov);
        chk({tag, "_dbz"}, DIVBYZERO, edbz);
        step();
        chk({tag, "_hold_fin"}, Finish, 1);
        chk({tag, "_hold_quo"}, Quo, eq);
        chk({tag, "_hold_rem"}, Rem, er);
    endtask

    initial begin
        RST      = 1'b1;
        DIVIDEND = 10'd123;
        DIVISOR  = 5'd4;
        SIGNED   = 1'b0;
        Start    = 1'b0;
        step();
        step();
        chk("rst_quo", Quo, 0);
        chk("rst_rem", Rem, 0);
        chk("rst_fin", Finish, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_ov", OV, 0);
        chk("rst_dbz", DIVBYZERO, 0);
        RST = 1'b0;
        step();
        chk("idle_fin", Finish, 0);

        // Unsigned cases
        do_op("u75_0",   10'd75,  5'd0,  1'b0, 5'd0,  5'd0, 1'b0, 1'b1, 0, 1'b0);
        do_op("u188_14", 10'd188, 5'd14, 1'b0, 5'd13, 5'd6, 1'b0, 1'b0, 6, 1'b0);
        do_op("u240_10", 10'd240, 5'd10, 1'b0, 5'd24, 5'd0, 1'b0, 1'b0, 6, 1'b0);
        do_op("u152_5",  10'd152, 5'd5,  1'b0, 5'd30, 5'd2, 1'b0, 1'b0, 6, 1'b0);
        do_op("u199_19", 10'd199, 5'd19, 1'b0, 5'd10, 5'd9, 1'b0, 1'b0, 6, 1'b0);
        do_op("u31_5",   10'd31,  5'd5,  1'b0, 5'd6,  5'd1, 1'b0, 1'b0, 6, 1'b0);
        do_op("u7_2",    10'd7,   5'd2,  1'b0, 5'd3,  5'd1, 1'b0, 1'b0, 6, 1'b0);
        do_op("u71_1",   10'd71,  5'd1,  1'b0, 5'd0,  5'd0, 1'b1, 1'b0, 0, 1'b0);

        // Signed cases
        do_op("sm100_7", 10'b1110011100, 5'd7, 1'b1, 5'b10010, 5'b11110, 1'b0, 1'b0, 6, 1'b0);
        do_op("s112_7",  10'd112,        5'd7, 1'b1, 5'd0,     5'd0,     1'b1, 1'b0, 6, 1'b0);
        do_op("sm112_7", 10'd912,        5'd7, 1'b1, 5'b10000, 5'd0,     1'b0, 1'b0, 6, 1'b0);

        // Start re-pulsed during CALC is ignored
        do_op("repulse", 10'd188, 5'd14, 1'b0, 5'd13, 5'd6, 1'b0, 1'b0, 6, 1'b1);

        // Reset during CALC iteration 3 discards the operation
        DIVIDEND = 10'd240;
        DIVISOR  = 5'd10;
        SIGNED   = 1'b0;
        Start    = 1'b1;
        step();                         // edge 0
        Start    = 1'b0;
        chk("mid_busy", Busy, 1);
        step();
        step();
        step();                         // iteration 3 done
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("mid_rst_quo", Quo, 0);
        chk("mid_rst_rem", Rem, 0);
        chk("mid_rst_fin", Finish, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_ov", OV, 0);
        chk("mid_rst_dbz", DIVBYZERO, 0);
        for (int i = 0; i < 8; i++) step();
        chk("mid_rst_idle_fin", Finish, 0);
        chk("mid_rst_idle_busy", Busy, 0);

        // Operation following the reset completes normally
        do_op("after_rst", 10'd199, 5'd19, 1'b0, 5'd10, 5'd9, 1'b0, 1'b0, 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
